// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared states, port indices and arbitration helper
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  function automatic logic rr_pick(input logic p0_valid, input logic p1_valid,
                                   input logic last_grant);
    if (p0_valid && p1_valid) begin
      return ~last_grant;
    end else if (p0_valid) begin
      return PORT_IF;
    end else begin
      return PORT_LS;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// rtl/mem_port_arbiter_mux2.sv - generic 2:1 multiplexer
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter onto one memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic        p1_valid,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  input  logic        p0_we,
  input  logic        p1_we,
  output logic        p0_ready,
  output logic        p1_ready,
  output logic        p0_resp_valid,
  output logic        p1_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        grant
);

  state_t r_state;
  state_t w_next_state;
  logic   r_grant;
  logic   r_last_grant;
  logic   w_load_grant;
  logic   w_win;

  // State, grant and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= PORT_IF;
      r_last_grant <= PORT_LS;
    end else begin
      r_state <= w_next_state;
      if (w_load_grant) begin
        r_grant      <= w_win;
        r_last_grant <= w_win;
      end
    end
  end

  // Next-state decode plus handshake outputs for the granted port only.
  always_comb begin
    w_next_state  = r_state;
    w_load_grant  = 1'b0;
    w_win         = rr_pick(p0_valid, p1_valid, r_last_grant);
    mem_valid     = 1'b0;
    p0_ready      = 1'b0;
    p1_ready      = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (p0_valid || p1_valid) begin
          w_load_grant = 1'b1;
          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          p0_ready     = (r_grant == PORT_IF);
          p1_ready     = (r_grant == PORT_LS);
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        // Writes also park here until the memory acknowledges them.
        if (mem_resp_valid) begin
          p0_resp_valid = (r_grant == PORT_IF);
          p1_resp_valid = (r_grant == PORT_LS);
          w_next_state  = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  mux2 #(.W(32)) u_addr_mux (
    .i_a   (p0_addr),
    .i_b   (p1_addr),
    .i_sel (r_grant),
    .o_y   (mem_addr)
  );

  mux2 #(.W(32)) u_wdata_mux (
    .i_a   (p0_wdata),
    .i_b   (p1_wdata),
    .i_sel (r_grant),
    .o_y   (mem_wdata)
  );

  assign mem_we     = r_grant ? p1_we : p0_we;
  assign resp_rdata = mem_rdata;
  assign grant      = r_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_we, p1_we;
  logic        p0_ready, p1_ready, p0_resp_valid, p1_resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic        mem_ready, mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        grant;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .p0_valid       (p0_valid),
    .p1_valid       (p1_valid),
    .p0_addr        (p0_addr),
    .p1_addr        (p1_addr),
    .p0_wdata       (p0_wdata),
    .p1_wdata       (p1_wdata),
    .p0_we          (p0_we),
    .p1_we          (p1_we),
    .p0_ready       (p0_ready),
    .p1_ready       (p1_ready),
    .p0_resp_valid  (p0_resp_valid),
    .p1_resp_valid  (p1_resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_ready      (mem_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .grant          (grant)
  );

  typedef struct {
    logic        rst;
    logic        p0v;
    logic [31:0] p0a;
    logic        p1v;
    logic [31:0] p1a;
    logic        mr;
    logic        mrv;
    logic [31:0] mrd;
    logic        e_mv;
    logic [31:0] e_ma;
    logic        e_gnt;
    logic        e_p0r;
    logic        e_p1r;
    logic        e_p0rv;
    logic        e_p1rv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic p0v, input logic [31:0] p0a,
                     input logic p1v, input logic [31:0] p1a,
                     input logic mr, input logic mrv, input logic [31:0] mrd,
                     input logic e_mv, input logic [31:0] e_ma, input logic e_gnt,
                     input logic e_p0r, input logic e_p1r,
                     input logic e_p0rv, input logic e_p1rv);
    vec_t v;
    v.rst = r; v.p0v = p0v; v.p0a = p0a; v.p1v = p1v; v.p1a = p1a;
    v.mr = mr; v.mrv = mrv; v.mrd = mrd;
    v.e_mv = e_mv; v.e_ma = e_ma; v.e_gnt = e_gnt;
    v.e_p0r = e_p0r; v.e_p1r = e_p1r; v.e_p0rv = e_p0rv; v.e_p1rv = e_p1rv;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int ready_pulses;

  initial begin
    rst = 1'b1;
    p0_valid = 1'b0; p1_valid = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    p0_we = 1'b0; p1_we = 1'b0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

    //  rst p0v p0a          p1v p1a          mr mrv mrd            mv ma           g  p0r p1r p0rv p1rv
    // reset state
    add(0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 0);
    // single read on port 0
    add(0, 1, 32'h1000,    0, 32'h0,       0, 0, 32'h0,        0, 32'h1000,    0, 0, 0, 0, 0);
    add(0, 1, 32'h1000,    0, 32'h0,       1, 0, 32'h0,        1, 32'h1000,    0, 1, 0, 0, 0);
    add(0, 0, 32'h1000,    0, 32'h0,       0, 1, 32'hDEADBEEF, 0, 32'h1000,    0, 0, 0, 1, 0);
    add(0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 0);
    // re-reset, then contention: 0,1,0
    add(1, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 0);
    add(0, 1, 32'h100,     1, 32'h200,     0, 0, 32'h0,        0, 32'h100,     0, 0, 0, 0, 0);
    add(0, 1, 32'h100,     1, 32'h200,     1, 0, 32'h0,        1, 32'h100,     0, 1, 0, 0, 0);
    add(0, 1, 32'h100,     1, 32'h200,     0, 1, 32'h11,       0, 32'h100,     0, 0, 0, 1, 0);
    add(0, 1, 32'h100,     1, 32'h200,     0, 0, 32'h0,        0, 32'h100,     0, 0, 0, 0, 0);
    add(0, 1, 32'h100,     1, 32'h200,     1, 0, 32'h0,        1, 32'h200,     1, 0, 1, 0, 0);
    add(0, 1, 32'h100,     1, 32'h200,     0, 1, 32'h22,       0, 32'h200,     1, 0, 0, 0, 1);
    add(0, 1, 32'h100,     1, 32'h200,     0, 0, 32'h0,        0, 32'h200,     1, 0, 0, 0, 0);
    add(0, 1, 32'h100,     1, 32'h200,     1, 0, 32'h0,        1, 32'h100,     0, 1, 0, 0, 0);
    add(0, 0, 32'h100,     0, 32'h200,     0, 1, 32'h33,       0, 32'h100,     0, 0, 0, 1, 0);
    // stray response in IDLE, then in REQ
    add(0, 0, 32'h0,       0, 32'h0,       0, 1, 32'h77,       0, 32'h0,       0, 0, 0, 0, 0);
    add(0, 0, 32'h0,       1, 32'h300,     0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 0);
    add(0, 0, 32'h0,       1, 32'h300,     0, 1, 32'h88,       1, 32'h300,     1, 0, 0, 0, 0);
    add(0, 0, 32'h0,       1, 32'h300,     1, 0, 32'h0,        1, 32'h300,     1, 0, 1, 0, 0);
    add(0, 0, 32'h0,       0, 32'h300,     0, 1, 32'h33,       0, 32'h300,     1, 0, 0, 0, 1);
    // reset while waiting in RESP
    add(0, 1, 32'h500,     0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       1, 0, 0, 0, 0);
    add(0, 1, 32'h500,     0, 32'h0,       1, 0, 32'h0,        1, 32'h500,     0, 1, 0, 0, 0);
    add(0, 0, 32'h500,     0, 32'h0,       0, 0, 32'h0,        0, 32'h500,     0, 0, 0, 0, 0);
    add(1, 0, 32'h500,     0, 32'h0,       0, 0, 32'h0,        0, 32'h500,     0, 0, 0, 0, 0);
    add(0, 0, 32'h0,       0, 32'h0,       0, 1, 32'h44,       0, 32'h0,       0, 0, 0, 0, 0);
    add(0, 1, 32'h100,     1, 32'h200,     0, 0, 32'h0,        0, 32'h100,     0, 0, 0, 0, 0);
    add(0, 1, 32'h100,     1, 32'h200,     1, 0, 32'h0,        1, 32'h100,     0, 1, 0, 0, 0);
    add(0, 0, 32'h100,     0, 32'h200,     0, 1, 32'h55,       0, 32'h100,     0, 0, 0, 1, 0);
    add(0, 0, 32'h0,       0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst;
      p0_valid = vecs[i].p0v; p0_addr = vecs[i].p0a;
      p1_valid = vecs[i].p1v; p1_addr = vecs[i].p1a;
      mem_ready = vecs[i].mr; mem_resp_valid = vecs[i].mrv; mem_rdata = vecs[i].mrd;
      #4;
      chk($sformatf("v%0d mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_mv));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_ma);
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d p0_ready", i), 32'(p0_ready), 32'(vecs[i].e_p0r));
      chk($sformatf("v%0d p1_ready", i), 32'(p1_ready), 32'(vecs[i].e_p1r));
      chk($sformatf("v%0d p0_resp_valid", i), 32'(p0_resp_valid), 32'(vecs[i].e_p0rv));
      chk($sformatf("v%0d p1_resp_valid", i), 32'(p1_resp_valid), 32'(vecs[i].e_p1rv));
      if (vecs[i].e_p0rv || vecs[i].e_p1rv)
        chk($sformatf("v%0d resp_rdata", i), resp_rdata, vecs[i].mrd);
    end

    // Port 1 write with three wait states; request must stay stable.
    ready_pulses = 0;
    @(posedge clk); #1;
    rst = 1'b0; mem_resp_valid = 1'b0; mem_ready = 1'b0;
    p0_valid = 1'b0; p0_addr = 32'h0;
    p1_valid = 1'b1; p1_addr = 32'h40; p1_wdata = 32'h12345678; p1_we = 1'b1;
    #4;
    ready_pulses += int'(p1_ready);
    chk("wr idle mem_valid", 32'(mem_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #5;
      ready_pulses += int'(p1_ready);
      chk($sformatf("wr wait%0d mem_valid", k), 32'(mem_valid), 32'd1);
      chk($sformatf("wr wait%0d mem_addr", k), mem_addr, 32'h40);
      chk($sformatf("wr wait%0d mem_wdata", k), mem_wdata, 32'h12345678);
      chk($sformatf("wr wait%0d mem_we", k), 32'(mem_we), 32'd1);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #4;
    ready_pulses += int'(p1_ready);
    chk("wr accept mem_valid", 32'(mem_valid), 32'd1);
    chk("wr accept p1_ready", 32'(p1_ready), 32'd1);
    chk("wr accept p0_ready", 32'(p0_ready), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1; p1_valid = 1'b0; mem_resp_valid = 1'b1;
    #4;
    ready_pulses += int'(p1_ready);
    chk("wr ack p1_resp_valid", 32'(p1_resp_valid), 32'd1);
    chk("wr ack mem_valid", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_resp_valid = 1'b0;
    #4;
    ready_pulses += int'(p1_ready);
    chk("wr done p1_resp_valid", 32'(p1_resp_valid), 32'd0);
    chk("wr p1_ready pulses", 32'(ready_pulses), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
